// File: rtl/bram_program_loader.sv
// Byte-stream loader for BRAM port A: reads a little-endian word-count header,
// then writes each assembled little-endian payload word at consecutive word addresses.
module bram_program_loader #(
  parameter int unsigned DATAW    = 32,
  parameter int unsigned ADDRW    = 12,
  parameter int unsigned WORD_LEN = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_in_valid,
  input  logic [7:0]              i_in_data,
  output logic                    o_in_ready,
  output logic                    o_ram_we,
  output logic [ADDRW-1:0]        o_ram_addr,
  output logic [DATAW-1:0]        o_ram_din,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [ADDRW-WORD_LEN:0] o_words_written
);

  localparam int unsigned WCW = ADDRW - WORD_LEN + 1;
  localparam logic [31:0] CAP = 32'(1) << (ADDRW - WORD_LEN);

  typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE} state_t;

  state_t           r_state, w_state_d;
  logic [1:0]       r_idx, w_idx_d;
  logic [23:0]      r_shift, w_shift_d;
  logic [WCW-1:0]   r_len, w_len_d;
  logic [WCW-1:0]   r_words, w_words_d;
  logic             r_we, w_we_d;
  logic [ADDRW-1:0] r_addr, w_addr_d;
  logic [DATAW-1:0] r_din, w_din_d;
  logic             r_err, w_err_d;

  logic             w_accept;
  logic [31:0]      w_word;
  logic [WCW-1:0]   w_words_inc;

  assign o_in_ready      = (r_state != S_DONE);
  assign o_busy          = (r_state == S_DATA);
  assign o_done          = (r_state == S_DONE);
  assign o_err           = r_err;
  assign o_ram_we        = r_we;
  assign o_ram_addr      = r_addr;
  assign o_ram_din       = r_din;
  assign o_words_written = r_words;

  assign w_accept    = i_in_valid && o_in_ready;
  assign w_word      = {i_in_data, r_shift};
  assign w_words_inc = r_words + WCW'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_LEN;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_shift_d = r_shift;
    w_len_d   = r_len;
    w_words_d = r_words;
    w_we_d    = 1'b0;
    w_addr_d  = r_addr;
    w_din_d   = r_din;
    w_err_d   = r_err;

    // clear wins over a byte accepted in the same cycle
    if (i_clear) begin
      w_state_d = S_LEN;
      w_idx_d   = 2'd0;
      w_shift_d = 24'd0;
      w_words_d = '0;
      w_err_d   = 1'b0;
    end else if (w_accept) begin
      w_idx_d = r_idx + 2'd1;
      case (r_idx)
        2'd0: w_shift_d[7:0]   = i_in_data;
        2'd1: w_shift_d[15:8]  = i_in_data;
        2'd2: w_shift_d[23:16] = i_in_data;
        default: begin
          w_shift_d = 24'd0;
          unique case (r_state)
            S_LEN: begin
              if (w_word == 32'd0) begin
                w_state_d = S_DONE;
              end else if (w_word > CAP) begin
                w_err_d   = 1'b1;
                w_state_d = S_DONE;
              end else begin
                w_len_d   = w_word[WCW-1:0];
                w_state_d = S_DATA;
              end
            end
            S_DATA: begin
              w_we_d    = 1'b1;
              w_addr_d  = {r_words[WCW-2:0], {WORD_LEN{1'b0}}};
              w_din_d   = w_word;
              w_words_d = w_words_inc;
              if (w_words_inc == r_len) begin
                w_state_d = S_DONE;
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
      r_len   <= '0;
      r_words <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_idx   <= w_idx_d;
      r_shift <= w_shift_d;
      r_len   <= w_len_d;
      r_words <= w_words_d;
      r_we    <= w_we_d;
      r_addr  <= w_addr_d;
      r_din   <= w_din_d;
      r_err   <= w_err_d;
    end
  end

endmodule

// File: tb/tb_bram_program_loader.sv
// Self-checking bench: byte-count model checked every cycle, plus literal strobe expectations.
module tb_bram_program_loader;

  localparam int CAP = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, ram_we, busy, done, err;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic [10:0] words_written;

  bram_program_loader #(.DATAW(32), .ADDRW(12), .WORD_LEN(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_din(ram_din),
    .o_busy(busy), .o_done(done), .o_err(err), .o_words_written(words_written)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: everything follows from how many bytes were accepted since the last clear/reset.
  logic [7:0]  mem [0:127];
  int          m_k = 0;
  logic        m_we = 1'b0;
  logic [11:0] m_addr = '0;
  logic [31:0] m_din = '0;

  function automatic logic [31:0] m_hdr();
    return {mem[3], mem[2], mem[1], mem[0]};
  endfunction
  function automatic logic m_bad();
    return (m_k >= 4) && (m_hdr() == 0 || m_hdr() > CAP);
  endfunction
  function automatic int m_words();
    return (m_k < 4 || m_bad()) ? 0 : (m_k - 4) / 4;
  endfunction
  function automatic logic m_done();
    return m_bad() || (m_k >= 4 && m_words() == int'(m_hdr()));
  endfunction
  function automatic logic m_err();
    return (m_k >= 4) && (m_hdr() > CAP);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k = 0; m_we = 1'b0; m_addr = '0; m_din = '0;
    end else begin
      cyc++;
      m_we = 1'b0;
      if (clear) begin
        m_k = 0;
      end else if (in_valid && !m_done()) begin
        mem[m_k] = in_data;
        m_k++;
        if (m_k > 4 && m_k % 4 == 0) begin
          m_we   = 1'b1;
          m_addr = 12'((m_k - 8));
          m_din  = {mem[m_k-1], mem[m_k-2], mem[m_k-3], mem[m_k-4]};
        end
      end
    end
  end

  logic [11:0] s_addr [$];
  logic [31:0] s_din [$];
  int          s_cyc [$];
  logic        s_done [$];

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(!m_done()));
    chk("ram_we", 32'(ram_we), 32'(m_we));
    chk("ram_addr", 32'(ram_addr), 32'(m_addr));
    chk("ram_din", ram_din, m_din);
    chk("busy", 32'(busy), 32'(m_k >= 4 && !m_done()));
    chk("done", 32'(done), 32'(m_done()));
    chk("err", 32'(err), 32'(m_err()));
    chk("words_written", 32'(words_written), 32'(m_words()));
    if (ram_we) begin
      s_addr.push_back(ram_addr); s_din.push_back(ram_din);
      s_cyc.push_back(cyc); s_done.push_back(done);
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b1; in_data = b;
    @(posedge clk); #1;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush_strobes();
    s_addr.delete(); s_din.delete(); s_cyc.delete(); s_done.delete();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    flush_strobes();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);

    // Two words back-to-back
    send_word(32'd2, 0);
    send_word(32'h12345678, 0);
    send_word(32'hDEADBEEF, 0);
    idle(3);
    chk("t1_nstrobes", 32'(s_addr.size()), 32'd2);
    if (s_addr.size() == 2) begin
      chk("t1_addr0", 32'(s_addr[0]), 32'h000);
      chk("t1_din0", s_din[0], 32'h12345678);
      chk("t1_addr1", 32'(s_addr[1]), 32'h004);
      chk("t1_din1", s_din[1], 32'hDEADBEEF);
      chk("t1_spacing", 32'(s_cyc[1] - s_cyc[0]), 32'd4);
      chk("t1_done_on_last", 32'(s_done[1]), 32'd1);
    end
    chk("t1_words", 32'(words_written), 32'd2);

    // Zero-length image
    do_clear();
    send_word(32'd0, 0);
    in_valid = 1'b0;
    chk("t2_done_next", 32'(done), 32'd1);
    chk("t2_err", 32'(err), 32'd0);
    idle(3);
    chk("t2_nstrobes", 32'(s_addr.size()), 32'd0);

    // Oversized header (N=1025)
    do_clear();
    send_word(32'd1025, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    idle(2);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_ready", 32'(in_ready), 32'd0);
    chk("t3_nstrobes", 32'(s_addr.size()), 32'd0);

    // 16 words with random gaps
    do_clear();
    chk("t4_err_cleared", 32'(err), 32'd0);
    send_word(32'd16, $urandom_range(0, 7));
    for (int w = 0; w < 16; w++)
      send_word(32'h0101_0101 * 32'(w) + 32'hA050_3010, $urandom_range(0, 7));
    idle(3);
    chk("t4_nstrobes", 32'(s_addr.size()), 32'd16);
    for (int w = 0; w < 16 && w < s_addr.size(); w++) begin
      chk("t4_addr", 32'(s_addr[w]), 32'(4 * w));
      chk("t4_din", s_din[w], 32'h0101_0101 * 32'(w) + 32'hA050_3010);
    end

    // Reset mid-load, then a 1-word image
    do_clear();
    send_word(32'd4, 0);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    send(8'h33, 0);
    send(8'h33, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_words", 32'(words_written), 32'd0);
    chk("t5_rst_addr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    flush_strobes();
    send_word(32'd1, 0);
    send_word(32'hCAFEF00D, 0);
    idle(2);
    chk("t5_nstrobes", 32'(s_addr.size()), 32'd1);
    if (s_addr.size() == 1) begin
      chk("t5_addr", 32'(s_addr[0]), 32'h000);
      chk("t5_din", s_din[0], 32'hCAFEF00D);
    end

    // clear with in_valid in S_DONE: that byte is dropped
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h05;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    flush_strobes();
    chk("t6_done_cleared", 32'(done), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    send_word(32'd1, 0);
    chk("t6_busy", 32'(busy), 32'd1);
    send_word(32'hDDCCBBAA, 0);
    idle(2);
    chk("t6_nstrobes", 32'(s_addr.size()), 32'd1);
    if (s_addr.size() == 1) begin
      chk("t6_addr", 32'(s_addr[0]), 32'h000);
      chk("t6_din", s_din[0], 32'hDDCCBBAA);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_program_loader.md
# bram_program_loader

Byte-stream writer for the core's dual-port instruction/data BRAM. It sits between the UART receive path and BRAM port A. It assembles a little-endian length header and payload words from a valid/ready byte stream, then issues one single-cycle write per word at consecutive word-aligned byte addresses starting at 0. It holds the core in load mode until the image is complete and signals completion with a level `done`.

## Interface
- `DATAW`, 32: RAM word width. Fixed at 32 (4 bytes per word).
- `ADDRW`, 12: RAM byte-address width. Must match the BRAM wrapper.
- `WORD_LEN`, 2: log2 of bytes per word. Addresses are word-aligned, so the low `WORD_LEN` bits are always 0.

- `clk` in 1: single clock. All state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous re-arm. Returns the block to `S_LEN` from any state.
- `in_valid` in 1: a byte is offered on `in_data`.
- `in_data` in 8: byte payload.
- `in_ready` out 1: the block accepts the byte this cycle.
- `ram_we` out 1: one-cycle write strobe to BRAM port A.
- `ram_addr` out ADDRW: byte address, always word-aligned.
- `ram_din` out DATAW: write data.
- `busy` out 1: a load is in progress (state `S_DATA`).
- `done` out 1: level; the load has finished (state `S_DONE`).
- `err` out 1: sticky; the header length exceeded capacity.
- `words_written` out ADDRW-WORD_LEN+1: count of write strobes issued in this load.

## Operation
- Capacity is `CAP = 2^(ADDRW-WORD_LEN)` words.
- A byte is accepted on a cycle where `in_valid && in_ready`.
- `in_ready` is 1 in `S_LEN` and `S_DATA`, and 0 in `S_DONE`.
- A 2-bit byte index and a 24-bit shift register collect bytes.
  - Byte k of a word lands in bits `[8k+7:8k]` (little-endian).
  - The index wraps 3→0 when the 4th byte is accepted.
- **`S_LEN`** (reset state): collects the 32-bit word count N.
  - When the 4th byte is accepted:
    - N == 0: go to `S_DONE`.
    - N > CAP: set `err` and go to `S_DONE`. No writes are issued.
    - Otherwise: latch N and go to `S_DATA`.
- **`S_DATA`**: each completed word registers `ram_din` = the assembled word and `ram_addr` = `words_written << WORD_LEN`, and pulses `ram_we`.
  - `words_written` increments with each strobe.
  - When the 4th byte of word N-1 is accepted, the state goes to `S_DONE`.
- **`S_DONE`**: holds until `rst` or `clear`.
  - No bytes are consumed.
  - Stray `in_valid` is ignored.
- **`clear`**:
  - Zeroes the byte index, the shift register, `words_written` and `err`.
  - Forces `S_LEN`.
  - Has priority over a byte accepted in the same cycle; that byte is discarded.
- **Reset values:**
  - State `S_LEN`.
  - `in_ready`=1.
  - `ram_we`=0, `ram_addr`=0, `ram_din`=0.
  - `busy`=0, `done`=0, `err`=0, `words_written`=0.
- `ram_addr` never wraps: `words_written` ≤ N ≤ CAP is guaranteed by the header check.

## Timing
- 4th byte of a word accepted at cycle t:
  - `ram_we`=1 at t+1, with `ram_addr`/`ram_din` valid.
  - `ram_we`=0 at t+2 unless another word completes at t+1.
- Throughput: one byte per cycle, no bubbles. Back-to-back words produce strobes every 4 cycles.
- The final word's strobe (t+1) coincides with the first cycle of `done`=1, `busy`=0, `in_ready`=0.
- Header completion at t:
  - `busy`=1 from t+1 (N valid).
  - Or `done`=1 from t+1 (N==0 or error). `err` is also set at t+1 in the error case.
- `in_ready` is a function of the state register only. It has no combinational path from `in_valid`.
- `rst` asserted mid-load: all outputs reach their reset values immediately. An in-flight `ram_we` is dropped.
- `in_valid` low mid-word: the byte index holds. Gaps of any length are legal.

## Test plan
- Header 02 00 00 00, then payload 78 56 34 12 EF BE AD DE sent back-to-back -> two strobes 4 cycles apart:
  - addr 0x000 with din 0x12345678;
  - addr 0x004 with din 0xDEADBEEF.
  - `done`=1 on the second strobe's cycle; `words_written`=2.
- Header 00 00 00 00 -> no `ram_we` ever; `done`=1 one cycle after the 4th byte; `err`=0.
- `ADDRW`=12 (CAP=1024), header 01 04 00 00 (N=1025) -> `err`=1, `done`=1, no strobes. Further bytes see `in_ready`=0.
- Random `in_valid` gaps of 0-7 cycles over a 16-word image -> 16 strobes at addresses 0x000..0x03C with data matching the image; no strobe while a word is partial.
- `rst` pulsed after 2.5 words of a 4-word image -> outputs at reset values; a fresh 1-word image (header + 4 bytes) loads to addr 0.
- `clear` asserted in `S_DONE` together with `in_valid` -> that byte is discarded, `err`/`done` cleared, and the next 4 bytes are parsed as a header.
